// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - single-outstanding SRAM-like request port to AXI3 master bridge
module sram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'b0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] mem_a,
  input  logic        mem_access,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_st_data,
  output logic        mem_ready,
  output logic [31:0] mem_data,
  input  logic        flush,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, st_data_q;
  logic [2:0]  size_q;
  logic [3:0]  strb_q;
  logic        cancel_q, aw_done_q, w_done_q;
  logic        start;
  logic        unused_inputs;

  assign start         = mem_access & ~flush;
  assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign araddr  = addr_q;
  assign arsize  = size_q;
  assign awid    = AXI_ID;
  assign awlen   = 4'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awaddr  = addr_q;
  assign awsize  = size_q;
  assign wid     = AXI_ID;
  assign wlast   = 1'b1;
  assign wdata   = st_data_q;
  assign wstrb   = strb_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      addr_q    <= '0;
      st_data_q <= '0;
      size_q    <= '0;
      strb_q    <= '0;
      mem_data  <= '0;
      cancel_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        addr_q    <= mem_a;
        st_data_q <= mem_st_data;
        strb_q    <= mem_sel;
        size_q    <= (mem_size == 2'b11) ? 3'b010 : {1'b0, mem_size};
      end
      // A flushed load still lands its data; only the completion pulse is dropped.
      if (state == RDATA && rvalid)
        mem_data <= rdata;
      if (state == IDLE || state == DONE)
        cancel_q <= 1'b0;
      else if (flush)
        cancel_q <= 1'b1;
      if (state == IDLE) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else if (state == WREQ) begin
        if (awvalid && awready) aw_done_q <= 1'b1;
        if (wvalid && wready)   w_done_q  <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    mem_ready = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = mem_write ? WREQ : RADDR;
      RADDR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = RDATA;
      end
      RDATA: begin
        rready = 1'b1;
        if (rvalid) state_nxt = DONE;
      end
      WREQ: begin
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
        if ((aw_done_q | awready) && (w_done_q | wready)) state_nxt = WRESP;
      end
      WRESP: begin
        bready = 1'b1;
        if (bvalid) state_nxt = DONE;
      end
      DONE: begin
        mem_ready = ~cancel_q & ~flush;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb/tb_sram_axi_bridge.sv - directed and randomized bench for sram_axi_bridge with a reactive AXI slave
module tb_sram_axi_bridge;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] mem_a, mem_st_data, mem_data;
  logic        mem_access, mem_write, mem_ready, flush;
  logic [1:0]  mem_size;
  logic [3:0]  mem_sel;
  logic [3:0]  arid, arcache, rid, awid, awlen, awcache, wid, wstrb, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_mem_data = '0;

  always #5 aclk = ~aclk;

  sram_axi_bridge #(.AXI_ID(4'b0000)) dut (
    .aclk(aclk), .aresetn(aresetn), .mem_a(mem_a), .mem_access(mem_access),
    .mem_write(mem_write), .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
    .mem_ready(mem_ready), .mem_data(mem_data), .flush(flush),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    arready = 0; rvalid = 0; rdata = '0; awready = 0; wready = 0; bvalid = 0;
  endtask

  // One request end to end. d1/d2/d3: ready/valid delays (AR,R) or (AW,W,B).
  // flush_at: cycle (1 = first cycle after the IDLE sample) carrying a flush pulse, -1 for none.
  task automatic run_txn(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                         input logic [3:0] sel, input logic [31:0] sd, input logic [31:0] rd,
                         input int d1, input int d2, input int d3, input int flush_at);
    int exp_done;
    bit exp_rdy;
    logic [2:0] exp_size;
    bit ar_d = 0, r_d = 0, aw_d = 0, w_d = 0, b_d = 0;
    int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    exp_size = (sz == 2'b11) ? 3'b010 : {1'b0, sz};
    exp_done = wr ? 3 + ((d1 > d2) ? d1 : d2) + d3 : 3 + d1 + d2;
    exp_rdy  = !(flush_at >= 1 && flush_at <= exp_done);
    @(negedge aclk);
    mem_a = a; mem_size = sz; mem_sel = sel; mem_st_data = sd; mem_write = wr;
    mem_access = 1; flush = 0;
    for (int cyc = 1; cyc <= exp_done + 1; cyc++) begin
      @(negedge aclk);
      flush = (cyc == flush_at);
      if (cyc == exp_done + 1) mem_access = 0;
      #1;
      chk("arvalid", arvalid, !wr && !ar_d);
      chk("rready",  rready,  !wr && ar_d && !r_d);
      chk("awvalid", awvalid, wr && !aw_d);
      chk("wvalid",  wvalid,  wr && !w_d);
      chk("bready",  bready,  wr && aw_d && w_d && !b_d);
      chk("mem_ready", mem_ready, (cyc == exp_done) && exp_rdy);
      if (arvalid) begin
        chk("araddr", araddr, a);
        chk("arsize", arsize, exp_size);
      end
      if (awvalid) begin
        chk("awaddr", awaddr, a);
        chk("awsize", awsize, exp_size);
      end
      if (wvalid) begin
        chk("wdata", wdata, sd);
        chk("wstrb", wstrb, sel);
        chk("wlast", wlast, 1'b1);
      end
      if (cyc == exp_done) begin
        if (!wr) model_mem_data = rd;
        chk("mem_data", mem_data, model_mem_data);
      end
      arready = arvalid && (ar_c >= d1);  if (arvalid) ar_c++;
      awready = awvalid && (aw_c >= d1);  if (awvalid) aw_c++;
      wready  = wvalid  && (w_c  >= d2);  if (wvalid)  w_c++;
      rvalid  = ar_d && !r_d && (r_c >= d2);
      if (ar_d && !r_d) r_c++;
      rdata   = rvalid ? rd : $urandom;
      bvalid  = aw_d && w_d && !b_d && (b_c >= d3);
      if (aw_d && w_d && !b_d) b_c++;
      ar_hs = arvalid && arready; r_hs = rvalid && rready;
      aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
      ar_d |= ar_hs; r_d |= r_hs; aw_d |= aw_hs; w_d |= w_hs; b_d |= b_hs;
    end
    slave_idle();
    chk("txn_complete", {27'd0, ar_d, r_d, aw_d, w_d, b_d},
        wr ? 32'h7 : 32'h18);
  endtask

  initial begin
    aresetn = 0; mem_a = '0; mem_access = 0; mem_write = 0; mem_size = '0; mem_sel = '0;
    mem_st_data = '0; flush = 0; rid = '0; rresp = '0; rlast = 1; bid = '0; bresp = '0;
    slave_idle();
    repeat (2) @(negedge aclk);
    #1;
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready, mem_ready}, '0);
    chk("rst_mem_data", mem_data, '0);
    chk("rst_addr", {araddr ^ awaddr, wdata}, '0);
    chk("rst_strb_size", {wstrb, arsize, awsize}, '0);
    chk("const_ar", {arid, arlen, arburst, arlock, arcache, arprot}, {4'd0, 8'd0, 2'b01, 2'd0, 4'd0, 3'd0});
    chk("const_aw", {awid, awlen, awburst, awlock, awcache, awprot}, {4'd0, 4'd0, 2'b01, 2'd0, 4'd0, 3'd0});
    chk("const_w", {wid, wlast}, {4'd0, 1'b1});
    @(negedge aclk);
    aresetn = 1;

    run_txn(0, 32'h1FC00000, 2'b10, 4'hF, 32'h0, 32'hDEADBEEF, 0, 0, 0, -1);
    run_txn(1, 32'h1FAF0003, 2'b00, 4'b1000, 32'hAB000000, 32'h0, 0, 2, 0, -1);
    run_txn(0, 32'h00001000, 2'b10, 4'hF, 32'h0, 32'h12345678, 5, 0, 0, -1);
    run_txn(0, 32'h00002004, 2'b10, 4'hF, 32'h0, 32'hCAFEF00D, 0, 2, 0, 3);
    run_txn(0, 32'h00002008, 2'b01, 4'h3, 32'h0, 32'h0BADF00D, 0, 0, 0, -1);
    run_txn(1, 32'h00003000, 2'b11, 4'hF, 32'h55AA55AA, 32'h0, 1, 1, 2, 5);

    // flush in IDLE blocks the request from starting
    @(negedge aclk);
    mem_access = 1; mem_write = 0; flush = 1;
    @(negedge aclk);
    mem_access = 0; flush = 0;
    #1;
    chk("idle_flush_no_start", {arvalid, awvalid}, 2'b00);

    // asynchronous reset while stuck in WREQ
    @(negedge aclk);
    mem_a = 32'h4000; mem_write = 1; mem_size = 2'b10; mem_sel = 4'hF; mem_st_data = 32'h1;
    mem_access = 1;
    @(negedge aclk);
    #1;
    chk("wreq_awvalid", {awvalid, wvalid}, 2'b11);
    #2;
    aresetn = 0;
    #1;
    chk("rst_wreq_valids", {awvalid, wvalid, bready, mem_ready}, 4'b0000);
    chk("rst_wreq_mem_data", mem_data, '0);
    model_mem_data = '0;
    mem_access = 0;
    @(negedge aclk);
    aresetn = 1;
    run_txn(0, 32'h00005000, 2'b10, 4'hF, 32'h0, 32'h600DCAFE, 0, 0, 0, -1);

    for (int i = 0; i < 24; i++) begin
      bit wr;
      int d1, d2, d3, lat, fa;
      wr = $urandom_range(0, 1);
      d1 = $urandom_range(0, 3); d2 = $urandom_range(0, 3); d3 = $urandom_range(0, 3);
      lat = wr ? 3 + ((d1 > d2) ? d1 : d2) + d3 : 3 + d1 + d2;
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat)) : -1;
      run_txn(wr, $urandom, 2'($urandom_range(0, 3)), 4'($urandom), $urandom, $urandom,
              d1, d2, d3, fa);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Single-port bridge from the CPU's SRAM-like memory request port to an AXI3 master interface.
- Sits directly downstream of the instruction/data request mux in the CPU top level and feeds the AXI interconnect.
- Keeps one transaction outstanding at a time, and only single beats (no bursts).
- Returns read data and a completion pulse to the mux, and drops the completion of a transaction that the pipeline flushes.

Parameters:
- AXI_ID, 4'b0000, value driven on arid/awid/wid.

Ports:
- aclk  input  1  clock; all state changes on the rising edge.
- aresetn  input  1  asynchronous active-low reset.
- mem_a  input  32  byte address of the request.
- mem_access  input  1  request valid; held stable by the requester until mem_ready.
- mem_write  input  1  1 = store, 0 = load.
- mem_size  input  2  00 byte, 01 half, 10 word (11 is treated as word).
- mem_sel  input  4  byte-lane write enables.
- mem_st_data  input  32  store data.
- mem_ready  output  1  one-cycle completion pulse.
- mem_data  output  32  registered load data.
- flush  input  1  cancels delivery of the current request's completion.
- araddr/arsize/arvalid  output  32/3/1  AXI read address channel.
- arready  input  1  read address accepted.
- arid, arlen[7:0], arburst, arlock, arcache, arprot  output  various  constants: AXI_ID, 0, 2'b01, 0, 0, 0.
- rdata/rvalid  input  32/1  AXI read data channel.
- rid, rresp, rlast  input  4/2/1  ignored.
- rready  output  1  read data accept.
- awaddr/awsize/awvalid  output  32/3/1  AXI write address channel.
- awready  input  1  write address accepted.
- awid, awlen[3:0], awburst, awlock, awcache, awprot  output  various  constants: AXI_ID, 0, 2'b01, 0, 0, 0.
- wdata/wstrb/wvalid  output  32/4/1  AXI write data channel.
- wid, wlast  output  4/1  constants AXI_ID, 1'b1.
- wready  input  1  write data accepted.
- bvalid  input  1  write response valid.
- bid, bresp  input  4/2  ignored.
- bready  output  1  write response accept.

Behaviour:
- Reset: asynchronous; asserting aresetn low immediately forces the FSM to IDLE and clears the cancel flag.
  - All valid and ready outputs go to 0 and mem_ready goes to 0.
  - mem_data and the address, data, size and strobe registers go to 0.
- Reset mid-transaction abandons the transaction with no further bus activity.
- FSM states: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- IDLE:
  - If mem_access is high and flush is low, latch mem_a, mem_size, mem_sel and mem_st_data.
  - Go to RADDR if mem_write is 0, otherwise WREQ.
  - If flush is high, no request starts.
- RADDR: arvalid=1 and stays high until arready. On arvalid&arready go to RDATA.
- RDATA: rready=1. On rvalid, capture rdata into mem_data and go to DONE.
- WREQ:
  - awvalid and wvalid both rise on entry.
  - Each channel drops independently after its own handshake; per-channel done flags are held.
  - Go to WRESP once both channels have completed, including the case where both complete in the same cycle.
- WRESP: bready=1. On bvalid go to DONE.
- DONE:
  - mem_ready = ~cancel & ~flush, for exactly one cycle; then unconditionally go to IDLE.
  - mem_access is not sampled in DONE, so a held request cannot re-issue.
- Cancel flag:
  - Set by flush in any non-IDLE state; cleared on return to IDLE.
  - Valid signals are never withdrawn before their handshake, as required by AXI; a cancelled transaction runs to completion on the bus and only mem_ready is suppressed.
  - A cancelled load still updates mem_data.
- Bus field encoding:
  - arsize/awsize = {1'b0, size}, with size 11 mapped to 010.
  - araddr and awaddr carry the latched address unmodified.
  - wstrb = latched mem_sel; wdata = latched store data.
- Timing: minimum load latency is 3 cycles from mem_access sampled in IDLE to the mem_ready cycle, with arready and rvalid each high at their first opportunity. Minimum store latency is also 3 cycles.
- Back-to-back: after a DONE cycle, a new request is sampled in the next IDLE cycle, so there is at least 1 idle cycle between transactions.

Test Plan:
- Word load, mem_a=0x1FC00000, mem_size=10, slave ready immediately with rdata=0xDEADBEEF:
  - araddr=0x1FC00000, arsize=010, arlen=0.
  - mem_ready pulses exactly in cycle 3 with mem_data=0xDEADBEEF.
- Byte store, mem_a=0x1FAF0003, mem_sel=4'b1000, mem_st_data=0xAB000000:
  - Slave gives awready 2 cycles before wready.
  - awvalid drops after its handshake while wvalid stays high; wstrb=1000, awsize=000, wlast=1.
  - mem_ready pulses once, one cycle after bvalid.
- arready held low for 5 cycles: arvalid and araddr stay stable throughout; rready=0 until the AR handshake completes.
- flush pulsed in RDATA: rready stays high; rdata is consumed; mem_ready stays 0; next request is accepted normally.
- aresetn low during WREQ: awvalid, wvalid and bready go to 0 immediately (before the next clock edge); after release, the FSM is in IDLE and a new load completes normally.
- mem_access held high through DONE: exactly one AXI transaction is issued per request; the next one starts only from IDLE.
